// File: rtl/frame_buffer_scanout_pkg.sv
// Shared types and helpers for frame_buffer_scanout.
//   pixel_t      : 9-bit stored pixel word {R,G,B}, 3 bits each
//   flags_t      : per-pixel raster flags carried down the output pipeline
//   clr_state_t  : clear-sweep FSM states (used when FB_CLEAR_ON_RESET_EN is defined)
//   raster_total : active + porches + sync, for H_TOTAL / V_TOTAL
//   SYNC_ACTIVE  : level of an asserted sync pulse (active low)
package frame_buffer_scanout_pkg;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } pixel_t;

    typedef struct packed {
        logic de;     // active pixel
        logic hs;     // hsync level
        logic vs;     // vsync level
        logic fs;     // first active pixel of the frame
        logic blank;  // force colour to 0 (clear sweep in progress)
    } flags_t;

    typedef enum logic {ST_IDLE, ST_CLEAR} clr_state_t;

    localparam logic SYNC_ACTIVE = 1'b0;

    function automatic int raster_total(input int active, input int front,
                                        input int sync, input int back);
        return active + front + sync + back;
    endfunction

endpackage

// File: rtl/frame_buffer_scanout_fb_ram.sv
// fb_ram: simple dual-port frame memory, one write port and one registered
// read port, both on the same clock. A read and a write to the same address
// in the same cycle returns the old word (read-before-write).
//   clock   : clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write word
//   rd_addr : read address
//   rd_data : registered read word
module fb_ram
    import frame_buffer_scanout_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  pixel_t            wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output pixel_t            rd_data
);

    pixel_t mem [0:(1<<ADDR_W)-1];

    // No reset: keeps the array mappable onto block RAM.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/frame_buffer_scanout.sv
// frame_buffer_scanout: pixel-write sink plus raster scan-out of a
// WIDTH x HEIGHT, 9-bit {R,G,B} frame buffer.
//   clock, not_reset      : clock, asynchronous active-low reset
//   iX, iY, iR, iG, iB    : write address / colour
//   iWren                 : write strobe, ignored while oBusy
//   oBusy                 : write port ignoring writes (clear sweep)
//   oHSync, oVSync        : active-low sync pulses
//   oDE                   : active-pixel enable
//   oR, oG, oB            : scanned colour, 0 outside active region
//   oFrameStart           : pulse with pixel (0,0)
// Optional feature macro FB_CLEAR_ON_RESET_EN: after reset release, write 0
// to every address (one per cycle) while holding oBusy and blanking colour.
// All outputs lag the raster counters by 2 cycles (address reg, RAM read).
module frame_buffer_scanout
    import frame_buffer_scanout_pkg::*;
#(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8,
    parameter int H_FRONT     = 8,
    parameter int H_SYNC      = 16,
    parameter int H_BACK      = 8,
    parameter int V_FRONT     = 2,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 4
) (
    input  logic                   clock,
    input  logic                   not_reset,
    input  logic [WIDTH_BITS-1:0]  iX,
    input  logic [HEIGHT_BITS-1:0] iY,
    input  logic [2:0]             iR,
    input  logic [2:0]             iG,
    input  logic [2:0]             iB,
    input  logic                   iWren,
    output logic                   oBusy,
    output logic                   oHSync,
    output logic                   oVSync,
    output logic                   oDE,
    output logic [2:0]             oR,
    output logic [2:0]             oG,
    output logic [2:0]             oB,
    output logic                   oFrameStart
);

    localparam int WIDTH  = 1 << WIDTH_BITS;
    localparam int HEIGHT = 1 << HEIGHT_BITS;
    localparam int H_TOT  = raster_total(WIDTH, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOT  = raster_total(HEIGHT, V_FRONT, V_SYNC, V_BACK);
    localparam int HC_W   = $clog2(H_TOT);
    localparam int VC_W   = $clog2(V_TOT);
    localparam int ADDR_W = WIDTH_BITS + HEIGHT_BITS;

    localparam logic [HC_W-1:0] H_ACT  = HC_W'(WIDTH);
    localparam logic [HC_W-1:0] H_LAST = HC_W'(H_TOT - 1);
    localparam logic [HC_W-1:0] HS_BEG = HC_W'(WIDTH + H_FRONT);
    localparam logic [HC_W-1:0] HS_END = HC_W'(WIDTH + H_FRONT + H_SYNC);
    localparam logic [VC_W-1:0] V_ACT  = VC_W'(HEIGHT);
    localparam logic [VC_W-1:0] V_LAST = VC_W'(V_TOT - 1);
    localparam logic [VC_W-1:0] VS_BEG = VC_W'(HEIGHT + V_FRONT);
    localparam logic [VC_W-1:0] VS_END = VC_W'(HEIGHT + V_FRONT + V_SYNC);

    localparam flags_t FLAGS_RST = '{de: 1'b0, hs: ~SYNC_ACTIVE, vs: ~SYNC_ACTIVE,
                                     fs: 1'b0, blank: 1'b0};

    logic [HC_W-1:0]   hcnt;
    logic [VC_W-1:0]   vcnt;
    logic [ADDR_W-1:0] rd_addr;
    flags_t            flags0;
    flags_t [2:1]      flag_pipe;
    pixel_t            rd_data;
    pixel_t            pix_out;
    logic              busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    pixel_t            wr_data;

    // ---------------- raster counters ----------------
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    always_comb begin
        flags0       = FLAGS_RST;
        flags0.de    = (hcnt < H_ACT) && (vcnt < V_ACT);
        flags0.hs    = (hcnt >= HS_BEG && hcnt < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        flags0.vs    = (vcnt >= VS_BEG && vcnt < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        flags0.fs    = (hcnt == '0) && (vcnt == '0);
        flags0.blank = busy;
    end

    // Stage 1 registers the read address alongside the flags; stage 2 is the
    // RAM read, so flags travel two stages to stay aligned with rd_data.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            rd_addr   <= '0;
            flag_pipe <= {FLAGS_RST, FLAGS_RST};
        end else begin
            rd_addr      <= {vcnt[HEIGHT_BITS-1:0], hcnt[WIDTH_BITS-1:0]};
            flag_pipe[1] <= flags0;
            flag_pipe[2] <= flag_pipe[1];
        end
    end

    // ---------------- write port / clear sweep ----------------
`ifdef FB_CLEAR_ON_RESET_EN
    clr_state_t        state, state_nxt;
    logic [ADDR_W-1:0] clr_addr;

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR) clr_addr <= clr_addr + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        wr_en     = iWren;
        wr_addr   = {iY, iX};
        wr_data   = '{r: iR, g: iG, b: iB};
        case (state)
            ST_CLEAR: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = clr_addr;
                wr_data = '0;
                if (clr_addr == '1) state_nxt = ST_IDLE;
            end
            default: ;
        endcase
    end
`else
    assign busy    = 1'b0;
    assign wr_en   = iWren;
    assign wr_addr = {iY, iX};
    assign wr_data = '{r: iR, g: iG, b: iB};
`endif

    fb_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // rd_data has no reset; masking with the (reset) DE flag makes the colour
    // outputs clear asynchronously with everything else.
    assign pix_out     = (flag_pipe[2].de && !flag_pipe[2].blank) ? rd_data : '0;
    assign oR          = pix_out.r;
    assign oG          = pix_out.g;
    assign oB          = pix_out.b;
    assign oDE         = flag_pipe[2].de;
    assign oHSync      = flag_pipe[2].hs;
    assign oVSync      = flag_pipe[2].vs;
    assign oFrameStart = flag_pipe[2].fs;
    assign oBusy       = busy;

endmodule

// File: tb/tb_frame_buffer_scanout.sv
// Bench for frame_buffer_scanout on a reduced raster so several frames fit:
// 16x8 active, H_TOTAL=16+8+16+8=48, V_TOTAL=8+2+2+4=16, frame=768 cycles.
// Output for pixel (x,y) of frame f appears at cycle 2 + 768*f + 48*y + x.
// Expected items are keyed by (epoch, cycle); epoch increments on each reset
// release and cycle counts clock edges since that release.
module tb_frame_buffer_scanout;

    localparam int WB = 4;
    localparam int HB = 3;
`ifdef FB_CLEAR_ON_RESET_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    localparam int K_FS = 0, K_DE = 1, K_HS = 2, K_VS = 3, K_PIX = 4, K_BUSY = 5;

    logic          clock = 1'b0;
    logic          not_reset = 1'b0;
    logic [WB-1:0] iX = '0;
    logic [HB-1:0] iY = '0;
    logic [2:0]    iR = '0, iG = '0, iB = '0;
    logic          iWren = 1'b0;
    logic          oBusy, oHSync, oVSync, oDE, oFrameStart;
    logic [2:0]    oR, oG, oB;

    frame_buffer_scanout #(
        .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .H_FRONT(8), .H_SYNC(16), .H_BACK(8),
        .V_FRONT(2), .V_SYNC(2), .V_BACK(4)
    ) dut (
        .clock(clock), .not_reset(not_reset), .iX(iX), .iY(iY), .iR(iR), .iG(iG),
        .iB(iB), .iWren(iWren), .oBusy(oBusy), .oHSync(oHSync), .oVSync(oVSync),
        .oDE(oDE), .oR(oR), .oG(oG), .oB(oB), .oFrameStart(oFrameStart)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         ep;
        int         cyc;
        int         kind;
        logic [8:0] val;
    } exp_t;

    exp_t  sb[$];
    int    total = 0, bad = 0;
    int    cyc = 0, epoch = 0;
    string knames[6] = '{"frame_start", "de", "hsync", "vsync", "pixel", "busy"};

    always @(posedge clock or negedge not_reset)
        if (!not_reset) cyc <= 0;
        else            cyc <= cyc + 1;

    task automatic chk(input string nm, input int c, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s ep=%0d cyc=%0d got=%h want=%h", nm, epoch, c, act, exp);
        end
    endtask

    function automatic void push(input int ep, input int c, input int k, input logic [8:0] v);
        exp_t e;
        e.ep = ep; e.cyc = c; e.kind = k; e.val = v;
        sb.push_back(e);
    endfunction

    function automatic logic [8:0] row6_val(input int x);
        logic [8:0] v;
        v = 9'((x * 37 + 5) % 512);
        return v;
    endfunction

    // Monitor: compare every expectation whose slot has arrived.
    always @(negedge clock) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].ep == epoch && sb[i].cyc == cyc) begin
                logic [8:0] act;
                case (sb[i].kind)
                    K_FS:    act = {8'd0, oFrameStart};
                    K_DE:    act = {8'd0, oDE};
                    K_HS:    act = {8'd0, oHSync};
                    K_VS:    act = {8'd0, oVSync};
                    K_PIX:   act = {oR, oG, oB};
                    default: act = {8'd0, oBusy};
                endcase
                chk(knames[sb[i].kind], cyc, act, sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic wait_cyc(input int t);
        int guard = 0;
        while (cyc != t) begin
            @(negedge clock);
            guard++;
            if (guard > 3000) begin
                chk("wait_timeout", cyc, 9'd0, 9'd1);
                return;
            end
        end
    endtask

    task automatic wr(input int t, input int x, input int y, input logic [8:0] v);
        wait_cyc(t);
        iX = WB'(x); iY = HB'(y); {iR, iG, iB} = v; iWren = 1'b1;
    endtask

    task automatic wr_idle();
        @(negedge clock);
        iWren = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hsync"}, cyc, {8'd0, oHSync}, 9'd1);
        chk({tag, "_vsync"}, cyc, {8'd0, oVSync}, 9'd1);
        chk({tag, "_de"}, cyc, {8'd0, oDE}, 9'd0);
        chk({tag, "_rgb"}, cyc, {oR, oG, oB}, 9'd0);
        chk({tag, "_fs"}, cyc, {8'd0, oFrameStart}, 9'd0);
        chk({tag, "_busy"}, cyc, {8'd0, oBusy}, {8'd0, CLR});
    endtask

    initial begin
        repeat (3) @(negedge clock);
        #1 chk_reset_outputs("por");

        // ---- epoch 1 expectations: timing ----
        push(1, 1, K_FS, 0);   push(1, 2, K_FS, 1);   push(1, 3, K_FS, 0);
        push(1, 770, K_FS, 1);
        push(1, 1, K_DE, 0);   push(1, 2, K_DE, 1);   push(1, 17, K_DE, 1);
        push(1, 18, K_DE, 0);  push(1, 353, K_DE, 1); push(1, 386, K_DE, 0);
        push(1, 25, K_HS, 1);  push(1, 26, K_HS, 0);  push(1, 41, K_HS, 0);
        push(1, 42, K_HS, 1);
        push(1, 481, K_VS, 1); push(1, 482, K_VS, 0); push(1, 577, K_VS, 0);
        push(1, 578, K_VS, 1);
        push(1, 127, K_BUSY, {8'd0, CLR});
        push(1, 128, K_BUSY, 0);
        if (CLR) push(1, 2, K_PIX, 0);
        // ---- epoch 1 expectations: pixel data ----
        push(1, 867, K_PIX, CLR ? 9'h000 : 9'h1FF);  // (1,2), written during sweep if clear on
        push(1, 918, K_PIX, 9'o123);                 // (4,3)
        push(1, 919, K_PIX, 9'o705);                 // (5,3)
        push(1, 919, K_DE, 1);
        push(1, 920, K_PIX, 9'o333);                 // (6,3)
        for (int x = 0; x < 16; x++) push(1, 1058 + x, K_PIX, row6_val(x));
        push(1, 820, K_PIX, 9'h0AA);                 // (2,1) collision: old value
        push(1, 821, K_PIX, 9'h0F0);                 // (3,1) written one cycle before its read
        push(1, 1588, K_PIX, 9'h155);                // (2,1) new value, next frame
        push(1, 1738, K_PIX, 9'h1C7);                // (8,4) frame 2
        push(1, 1738, K_DE, 1);

        @(negedge clock);
        #2 not_reset = 1'b1; epoch = 1;

        wr(100, 1, 2, 9'h1FF); wr_idle();
        wr(200, 5, 3, 9'o705);
        wr(201, 4, 3, 9'o123);
        wr(202, 6, 3, 9'o333); wr_idle();
        for (int x = 0; x < 16; x++) wr(210 + x, x, 6, row6_val(x));
        wr_idle();
        wr(230, 2, 1, 9'h0AA);
        wr(231, 8, 4, 9'h1C7); wr_idle();
        // (2,1): counters at cycle 818, address reg/RAM read in cycle 819.
        wr(818, 3, 1, 9'h0F0);
        wr(819, 2, 1, 9'h155); wr_idle();

        // ---- reset mid-line while DE is high ----
        wait_cyc(1738);
        #2 not_reset = 1'b0;
        #1 chk_reset_outputs("midrst");
        repeat (2) @(negedge clock);

        push(2, 2, K_FS, 1);   push(2, 2, K_DE, 1);
        push(2, 25, K_HS, 1);  push(2, 26, K_HS, 0);
        push(2, 127, K_BUSY, {8'd0, CLR});
        push(2, 128, K_BUSY, 0);
        push(2, 151, K_PIX, CLR ? 9'h000 : 9'o705);  // (5,3) retained
        push(2, 202, K_PIX, CLR ? 9'h000 : 9'h1C7);  // (8,4) retained
        push(2, 293, K_PIX, CLR ? 9'h000 : row6_val(3));
        #2 not_reset = 1'b1; epoch = 2;

        wait_cyc(400);
        chk("scoreboard_drained", cyc, 9'(sb.size()), 9'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_buffer_scanout.md
# frame_buffer_scanout

Pixel-write sink and raster scan-out for the thresholding pipeline. It accepts the single-pixel write stream produced by the processing top level (X, Y, 3-bit R/G/B, write strobe) and stores it in a WIDTH×HEIGHT frame buffer. It continuously reads the buffer back in raster order with programmable sync timing, so the result can be viewed on a display.

## Interface
Parameters:
- WIDTH_BITS, 8, log2 of active width; WIDTH = 2**WIDTH_BITS
- HEIGHT_BITS, 8, log2 of active height; HEIGHT = 2**HEIGHT_BITS
- H_FRONT, 8, horizontal front porch in pixels
- H_SYNC, 16, horizontal sync width in pixels
- H_BACK, 8, horizontal back porch in pixels
- V_FRONT, 2, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BACK, 4, vertical back porch in lines

Ports:
- clock  in  1  single clock; one pixel per cycle on both ports
- not_reset  in  1  asynchronous, active-low reset
- iX  in  WIDTH_BITS  write column
- iY  in  HEIGHT_BITS  write row
- iR, iG, iB  in  3 each  write colour
- iWren  in  1  write strobe; one pixel per high cycle
- oBusy  out  1  high while the write port ignores writes
- oHSync, oVSync  out  1 each  active-low sync pulses
- oDE  out  1  data enable, high on active pixels
- oR, oG, oB  out  3 each  scanned pixel colour; 0 when oDE=0
- oFrameStart  out  1  one-cycle pulse aligned with the first active pixel (0,0) of each frame

## Operation
- Storage: WIDTH*HEIGHT words of 9 bits, {R,G,B}; address = {iY, iX}.
- Write port:
  - If iWren=1 and oBusy=0, the pixel is written at the clock edge.
  - Writes while busy are dropped silently.
  - No range check is needed; the port widths are exact.
- Raster counters:
  - hcnt runs 0..H_TOTAL-1, where H_TOTAL = WIDTH+H_FRONT+H_SYNC+H_BACK (288 at defaults).
  - vcnt runs 0..V_TOTAL-1, where V_TOTAL = HEIGHT+V_FRONT+V_SYNC+V_BACK (264 at defaults).
  - vcnt increments when hcnt wraps; both wrap to 0.
- Active region: hcnt<WIDTH and vcnt<HEIGHT. During the active region the read address is {vcnt[HEIGHT_BITS-1:0], hcnt[WIDTH_BITS-1:0]}.
- HSync is asserted (low) for WIDTH+H_FRONT ≤ hcnt < WIDTH+H_FRONT+H_SYNC.
- VSync is asserted (low) for HEIGHT+V_FRONT ≤ vcnt < HEIGHT+V_FRONT+V_SYNC, over whole lines.
- Read/write collision on the same address in the same cycle: the read returns the old data (read-before-write). The new value appears on the next frame.
- Scan-out never stalls and is independent of write traffic.

## Timing
- Reset values:
  - hcnt=vcnt=0
  - oHSync=1, oVSync=1, oDE=0, oR/oG/oB=0, oFrameStart=0
  - oBusy=1 with FB_CLEAR_ON_RESET_EN, else 0
- Output latency is 2 cycles from the counters: one cycle for address registration, one for RAM read.
  - The sync, DE and frame-start flags are delayed by the same 2-stage pipeline, so all outputs stay mutually aligned.
  - The first oFrameStart after reset release is at cycle 2.
- Write-to-visible latency: a write at cycle t is visible on any scan read of that address at cycle ≥ t+1.
- Reset mid-frame: counters restart at (0,0) and output registers clear immediately (asynchronously). Buffer contents are retained unless the clear feature is compiled in.

## Configuration
- FB_CLEAR_ON_RESET_EN defined:
  - After reset release, a clear sweep writes 0 to every address, one per cycle, for WIDTH*HEIGHT cycles (65536 at defaults).
  - oBusy=1 throughout the sweep and falls the cycle after the last address is written.
  - Scan-out runs during the sweep, with oR/oG/oB forced to 0.
- Undefined: there is no sweep, oBusy is tied to 0, and buffer contents after power-up are undefined.

## Structure
- Shared package: pixel word typedef (9-bit {R,G,B}), the H_TOTAL/V_TOTAL derivation helpers, and the sync-polarity constant.
- Sub-module fb_ram: simple dual-port RAM (1 write, 1 registered read, read-before-write) that infers block RAM.
- The top holds the raster counters, the 2-stage flag pipeline and the clear FSM (IDLE/CLEAR).

## Test plan
- Reset release, no writes (clear disabled): oFrameStart at cycle 2, then every 288*264=76032 cycles; oDE high for 256 consecutive cycles per line; HSync low for 16 cycles, starting 8 cycles after DE falls.
- Write (X=5,Y=3,RGB=7/0/5) -> in the next frame, at the oDE cycle for pixel (5,3), {oR,oG,oB}={7,0,5}; neighbouring pixels are unchanged.
- Write to the address being scanned in the same cycle -> old value shown; new value shown in the following frame.
- With FB_CLEAR_ON_RESET_EN: oBusy high for exactly 65536 cycles; a write issued at cycle 100 is dropped (it reads back 0 in a later frame); a write after oBusy falls succeeds.
- Assert not_reset mid-line (hcnt≈120, vcnt≈40) -> all outputs go to reset values immediately; after release, timing restarts at (0,0) and previously written pixels remain (clear disabled).
- Back-to-back writes on 256 consecutive cycles filling row 10 -> the full row reads back correctly with no drops.
